// File: rtl/day_of_year_counter.sv
// Day-of-year calendar counter: binary and BCD day count, incremental month and
// day-of-month tracking with leap-year support, and a sequential load path that
// decodes an arbitrary day number into month/day with an iterative walk.
// Optional feature macro: DOY_DOWN_COUNT_EN (adds a 'dir' port for down counting).
module day_of_year_counter #(
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned START_DAY = 1,
  parameter int unsigned LIMIT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
`ifdef DOY_DOWN_COUNT_EN
  input  logic             dir,
`endif
  input  logic             leap,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic [11:0]      cnt_bcd,
  output logic [3:0]       month,
  output logic [7:0]       dom_bcd,
  output logic             wrap,
  output logic             busy,
  output logic             load_err
);

  localparam bit              HAS_LIMIT = (LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_V  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] START_V  = CNT_W'(START_DAY);
  localparam logic [11:0]     START_BCD = {4'(START_DAY / 100), 4'((START_DAY / 10) % 10),
                                           4'(START_DAY % 10)};
  localparam logic [7:0]      START_DOM = START_BCD[7:0];

  typedef enum logic {ST_RUN, ST_WALK} state_t;

  state_t           state;
  logic             leap_q;
  logic [CNT_W-1:0] rem;      // month-walk remainder
  logic [CNT_W-1:0] wrem;     // BCD-walk remainder
  logic             m_done;
  logic             b_done;

  logic [CNT_W-1:0] end_cur;
  logic [CNT_W-1:0] end_new;
  logic [4:0]       cur_len;
  logic [4:0]       dom_bin;
  logic             m_fin;
  logic             b_fin;

  // Days in month m for the given leap flag
  function automatic logic [4:0] mlen(input logic [3:0] m, input logic lp);
    logic [4:0] r;
    case (m)
      4'd2:                       r = 5'd28 + {4'd0, lp};
      4'd4, 4'd6, 4'd9, 4'd11:    r = 5'd30;
      default:                    r = 5'd31;
    endcase
    return r;
  endfunction

  // Binary 0..31 to two-digit BCD
  function automatic logic [7:0] bcd8(input logic [4:0] v);
    logic [4:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 3; i++) begin
      if (r >= 5'd10) begin
        r = r - 5'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  // Two-digit BCD increment
  function automatic logic [7:0] bcd_inc8(input logic [7:0] b);
    logic [3:0] t, o;
    {t, o} = b;
    if (o == 4'd9) begin
      o = 4'd0;
      t = t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // Three-digit BCD increment
  function automatic logic [11:0] bcd_inc12(input logic [11:0] b);
    logic [3:0] h;
    logic [7:0] lo;
    h  = b[11:8];
    lo = bcd_inc8(b[7:0]);
    if (b[7:0] == 8'h99) begin
      lo = 8'h00;
      h  = h + 4'd1;
    end
    return {h, lo};
  endfunction

`ifdef DOY_DOWN_COUNT_EN
  // Two-digit BCD decrement
  function automatic logic [7:0] bcd_dec8(input logic [7:0] b);
    logic [3:0] t, o;
    {t, o} = b;
    if (o == 4'd0) begin
      o = 4'd9;
      t = t - 4'd1;
    end else begin
      o = o - 4'd1;
    end
    return {t, o};
  endfunction

  // Three-digit BCD decrement
  function automatic logic [11:0] bcd_dec12(input logic [11:0] b);
    logic [3:0] h;
    logic [7:0] lo;
    h  = b[11:8];
    lo = bcd_dec8(b[7:0]);
    if (b[7:0] == 8'h00) begin
      lo = 8'h99;
      h  = h - 4'd1;
    end
    return {h, lo};
  endfunction
`endif

  // Effective year end, current month length and walk completion flags
  always_comb begin
    end_cur = HAS_LIMIT ? LIMIT_V : CNT_W'(365) + CNT_W'(leap_q);
    end_new = HAS_LIMIT ? LIMIT_V : CNT_W'(365) + CNT_W'(leap);
    cur_len = mlen(month, leap_q);
    dom_bin = ({1'b0, dom_bcd[7:4]} * 5'd10) + {1'b0, dom_bcd[3:0]};
    m_fin   = m_done | (rem <= CNT_W'(cur_len));
    b_fin   = b_done | (wrem < CNT_W'(10));
  end

  // Counter, load validation and month/BCD walk state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      leap_q   <= leap;
      count    <= START_V;
      cnt_bcd  <= START_BCD;
      month    <= 4'd1;
      dom_bcd  <= START_DOM;
      wrap     <= 1'b0;
      busy     <= 1'b0;
      load_err <= 1'b0;
      rem      <= '0;
      wrem     <= '0;
      m_done   <= 1'b0;
      b_done   <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      case (state)
        ST_RUN: begin
          if (load) begin
            if (load_val == '0 || load_val > end_new) begin
              load_err <= 1'b1;
            end else begin
              leap_q  <= leap;
              count   <= load_val;
              rem     <= load_val;
              wrem    <= load_val;
              month   <= 4'd1;
              cnt_bcd <= '0;
              m_done  <= 1'b0;
              b_done  <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_WALK;
            end
          end else if (tick && run) begin
`ifdef DOY_DOWN_COUNT_EN
            if (dir) begin
              if (count == START_V) begin
                wrap   <= 1'b1;
                leap_q <= leap;
                if (HAS_LIMIT) begin
                  // Last day of a LIMIT period is not a fixed date; decode it
                  count   <= LIMIT_V;
                  rem     <= LIMIT_V;
                  wrem    <= LIMIT_V;
                  month   <= 4'd1;
                  cnt_bcd <= '0;
                  m_done  <= 1'b0;
                  b_done  <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ST_WALK;
                end else begin
                  count   <= CNT_W'(365) + CNT_W'(leap);
                  cnt_bcd <= {4'd3, 4'd6, 4'd5 + {3'd0, leap}};
                  month   <= 4'd12;
                  dom_bcd <= 8'h31;
                end
              end else begin
                count   <= count - CNT_W'(1);
                cnt_bcd <= bcd_dec12(cnt_bcd);
                if (dom_bcd == 8'h01) begin
                  month   <= month - 4'd1;
                  dom_bcd <= bcd8(mlen(month - 4'd1, leap_q));
                end else begin
                  dom_bcd <= bcd_dec8(dom_bcd);
                end
              end
            end else
`endif
            begin
              if (count == end_cur) begin
                count   <= START_V;
                cnt_bcd <= START_BCD;
                month   <= 4'd1;
                dom_bcd <= START_DOM;
                wrap    <= 1'b1;
                leap_q  <= leap;
              end else begin
                count   <= count + CNT_W'(1);
                cnt_bcd <= bcd_inc12(cnt_bcd);
                if (dom_bin == cur_len) begin
                  dom_bcd <= 8'h01;
                  month   <= month + 4'd1;
                end else begin
                  dom_bcd <= bcd_inc8(dom_bcd);
                end
              end
            end
          end
        end
        ST_WALK: begin
          // Month walk: peel whole months off the remainder
          if (!m_done) begin
            if (rem > CNT_W'(cur_len)) begin
              rem   <= rem - CNT_W'(cur_len);
              month <= month + 4'd1;
            end else begin
              dom_bcd <= bcd8(rem[4:0]);
              m_done  <= 1'b1;
            end
          end
          // BCD walk: hundreds, then tens, then ones
          if (!b_done) begin
            if (wrem >= CNT_W'(100)) begin
              wrem          <= wrem - CNT_W'(100);
              cnt_bcd[11:8] <= cnt_bcd[11:8] + 4'd1;
            end else if (wrem >= CNT_W'(10)) begin
              wrem         <= wrem - CNT_W'(10);
              cnt_bcd[7:4] <= cnt_bcd[7:4] + 4'd1;
            end else begin
              cnt_bcd[3:0] <= wrem[3:0];
              b_done       <= 1'b1;
            end
          end
          if (m_fin && b_fin) begin
            busy  <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_day_of_year_counter.sv
// Directed bench for day_of_year_counter: a default-year instance and a
// LIMIT=99 instance driven by the same stimulus.
module tb_day_of_year_counter;

  localparam int unsigned CNT_W = 9;

  logic             clk = 1'b0;
  logic             reset, tick, run, leap, load;
  logic [CNT_W-1:0] load_val;
`ifdef DOY_DOWN_COUNT_EN
  logic             dir = 1'b0;
`endif

  logic [CNT_W-1:0] count, count99;
  logic [11:0]      cnt_bcd, cnt_bcd99;
  logic [3:0]       month, month99;
  logic [7:0]       dom_bcd, dom_bcd99;
  logic             wrap, wrap99, busy, busy99, load_err, load_err99;

  day_of_year_counter #(.CNT_W(CNT_W), .START_DAY(1), .LIMIT(0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run),
`ifdef DOY_DOWN_COUNT_EN
    .dir(dir),
`endif
    .leap(leap), .load(load), .load_val(load_val),
    .count(count), .cnt_bcd(cnt_bcd), .month(month), .dom_bcd(dom_bcd),
    .wrap(wrap), .busy(busy), .load_err(load_err)
  );

  day_of_year_counter #(.CNT_W(CNT_W), .START_DAY(1), .LIMIT(99)) dut99 (
    .clk(clk), .reset(reset), .tick(tick), .run(run),
`ifdef DOY_DOWN_COUNT_EN
    .dir(dir),
`endif
    .leap(leap), .load(load), .load_val(load_val),
    .count(count99), .cnt_bcd(cnt_bcd99), .month(month99), .dom_bcd(dom_bcd99),
    .wrap(wrap99), .busy(busy99), .load_err(load_err99)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             tick;
    logic             run;
    logic             load;
    logic             leap;
    logic [CNT_W-1:0] lv;
    logic [CNT_W-1:0] ec;
    logic [11:0]      eb;
    logic [3:0]       em;
    logic [7:0]       ed;
    logic             ew;
    logic             ee;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for busy of the selected instance to fall, with a cycle budget
  task automatic wait_idle(input bit sel99, input string name, output int n);
    n = 0;
    while ((sel99 ? busy99 : busy) && n < 20) begin
      cyc();
      n++;
    end
    chk({name, "_busy_fell"}, 32'(sel99 ? busy99 : busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_count"}, 32'(count), 32'd1);
    chk({name, "_bcd"},   32'(cnt_bcd), 32'h001);
    chk({name, "_month"}, 32'(month), 32'd1);
    chk({name, "_dom"},   32'(dom_bcd), 32'h01);
    chk({name, "_busy"},  32'(busy), 32'd0);
    chk({name, "_wrap"},  32'(wrap), 32'd0);
    chk({name, "_err"},   32'(load_err), 32'd0);
  endtask

  initial begin
    int n;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd0,   9'd2, 12'h002, 4'd1, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd0,   9'd2, 12'h002, 4'd1, 8'h02, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd0,   9'd2, 12'h002, 4'd1, 8'h02, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd0,   9'd2, 12'h002, 4'd1, 8'h02, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd366, 9'd2, 12'h002, 4'd1, 8'h02, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'd366, 9'd2, 12'h002, 4'd1, 8'h02, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd0,   9'd3, 12'h003, 4'd1, 8'h03, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 9'd0,   9'd4, 12'h004, 4'd1, 8'h04, 1'b0, 1'b0};

    // Reset, with a concurrent load request that must be overridden
    reset = 1'b1; tick = 1'b0; run = 1'b1; leap = 1'b0; load = 1'b1; load_val = 9'd200;
    cyc();
    reset = 1'b0; load = 1'b0;
    chk_reset_vals("reset");
    chk("reset99_count", 32'(count99), 32'd1);

    // Single-cycle vectors: pause, load rejection, load-beats-tick, advance
    foreach (tbl[i]) begin
      tick = tbl[i].tick; run = tbl[i].run; load = tbl[i].load;
      leap = tbl[i].leap; load_val = tbl[i].lv;
      cyc();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_bcd", i),   32'(cnt_bcd), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_month", i), 32'(month), 32'(tbl[i].em));
      chk($sformatf("vec%0d_dom", i),   32'(dom_bcd), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_wrap", i),  32'(wrap), 32'(tbl[i].ew));
      chk($sformatf("vec%0d_err", i),   32'(load_err), 32'(tbl[i].ee));
    end
    tick = 1'b0; load = 1'b0; run = 1'b1;
    cyc();
    chk("err_one_cycle", 32'(load_err), 32'd0);

    // 59 ticks in a leap year land on Feb 29
    reset = 1'b1; leap = 1'b1; cyc(); reset = 1'b0;
    tick = 1'b1; repeat (59) cyc(); tick = 1'b0;
    chk("leap60_count", 32'(count), 32'd60);
    chk("leap60_bcd",   32'(cnt_bcd), 32'h060);
    chk("leap60_month", 32'(month), 32'd2);
    chk("leap60_dom",   32'(dom_bcd), 32'h29);

    // Non-leap year; leap raised after reset must not matter mid-year
    reset = 1'b1; leap = 1'b0; cyc(); reset = 1'b0; leap = 1'b1;
    tick = 1'b1; repeat (59) cyc(); tick = 1'b0;
    chk("nol60_count", 32'(count), 32'd60);
    chk("nol60_month", 32'(month), 32'd3);
    chk("nol60_dom",   32'(dom_bcd), 32'h01);

    // Load 365 (non-leap), decode, then wrap on the next tick
    leap = 1'b0; load = 1'b1; load_val = 9'd365; cyc(); load = 1'b0;
    chk("l365_busy", 32'(busy), 32'd1);
    chk("l365_count_busy", 32'(count), 32'd365);
    wait_idle(1'b0, "l365", n);
    chk("l365_walk_len_le13", 32'(n <= 13), 32'd1);
    chk("l365_month", 32'(month), 32'd12);
    chk("l365_dom",   32'(dom_bcd), 32'h31);
    chk("l365_bcd",   32'(cnt_bcd), 32'h365);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("wrap365_count", 32'(count), 32'd1);
    chk("wrap365_month", 32'(month), 32'd1);
    chk("wrap365_dom",   32'(dom_bcd), 32'h01);
    chk("wrap365_bcd",   32'(cnt_bcd), 32'h001);
    chk("wrap365_pulse", 32'(wrap), 32'd1);
    cyc();
    chk("wrap365_pulse_end", 32'(wrap), 32'd0);

    // LIMIT=99: load 98, then two ticks -> 99, then wrap to 1
    load = 1'b1; load_val = 9'd98; cyc(); load = 1'b0;
    wait_idle(1'b1, "l98", n);
    chk("l98_count", 32'(count99), 32'd98);
    chk("l98_month", 32'(month99), 32'd4);
    chk("l98_dom",   32'(dom_bcd99), 32'h08);
    chk("l98_bcd",   32'(cnt_bcd99), 32'h098);
    tick = 1'b1; cyc();
    chk("lim99_count", 32'(count99), 32'd99);
    chk("lim99_bcd",   32'(cnt_bcd99), 32'h099);
    chk("lim99_wrap0", 32'(wrap99), 32'd0);
    cyc(); tick = 1'b0;
    chk("lim1_count", 32'(count99), 32'd1);
    chk("lim1_bcd",   32'(cnt_bcd99), 32'h001);
    chk("lim1_month", 32'(month99), 32'd1);
    chk("lim1_wrap",  32'(wrap99), 32'd1);
    chk("lim_err365", 32'(load_err99), 32'd0);

    // Load samples leap: day 60 of a leap year is Feb 29; next day Mar 1
    leap = 1'b1; load = 1'b1; load_val = 9'd60; cyc(); load = 1'b0;
    wait_idle(1'b0, "l60", n);
    chk("l60_month", 32'(month), 32'd2);
    chk("l60_dom",   32'(dom_bcd), 32'h29);
    leap = 1'b0; tick = 1'b1; cyc(); tick = 1'b0;
    chk("l61_count", 32'(count), 32'd61);
    chk("l61_month", 32'(month), 32'd3);
    chk("l61_dom",   32'(dom_bcd), 32'h01);

    // Load 200 with ticks and a bad load during the walk: both ignored
    load = 1'b1; load_val = 9'd200; cyc(); load = 1'b0;
    tick = 1'b1; cyc();
    load = 1'b1; load_val = 9'd0; cyc(); load = 1'b0;
    chk("l200_no_err", 32'(load_err), 32'd0);
    chk("l200_count_busy", 32'(count), 32'd200);
    wait_idle(1'b0, "l200", n);
    tick = 1'b0;
    chk("l200_count", 32'(count), 32'd200);
    chk("l200_month", 32'(month), 32'd7);
    chk("l200_dom",   32'(dom_bcd), 32'h19);
    chk("l200_bcd",   32'(cnt_bcd), 32'h200);

    // Reset in the middle of a walk
    load = 1'b1; load_val = 9'd200; cyc(); load = 1'b0;
    tick = 1'b1; repeat (3) cyc();
    chk("midwalk_busy", 32'(busy), 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0; tick = 1'b0;
    chk_reset_vals("walk_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
